// File: rtl/rf_seq_alu_pkg.sv
// Shared types and default widths for the sequenced register-file execute stage.
//   DATA_W / ADDR_W : default operand and register-address widths
//   op_e            : operation encoding carried on in_op (6 and 7 are reserved)
//   state_e         : sequencer states
package rf_seq_alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_LI  = 3'd5
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_e;

   // Encodings above OP_LI carry no operation.
   function automatic logic op_reserved(input logic [2:0] op);
      return op > 3'(OP_LI);
   endfunction

endpackage

// File: rtl/rf_seq_alu_core.sv
// Combinational ALU for the execute stage.
//   op     : operation code (register-register ops only; others give 0)
//   a, b   : operands
//   result : a op b, subtraction wraps modulo 2^DATA_W
//   carry  : ADD carry-out / SUB borrow (only with RF_SEQ_ALU_FLAGS_EN)
// Optional feature macro: RF_SEQ_ALU_FLAGS_EN
module rf_seq_alu_core #(
   parameter int unsigned DATA_W = rf_seq_alu_pkg::DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
`ifdef RF_SEQ_ALU_FLAGS_EN
   ,
   output logic              carry
`endif
);
   import rf_seq_alu_pkg::*;

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

`ifdef RF_SEQ_ALU_FLAGS_EN
   // One extra bit holds ADD carry-out; for SUB it is set exactly when a < b.
   logic [DATA_W:0] sum_x;
   logic [DATA_W:0] diff_x;

   assign sum_x  = {1'b0, a} + {1'b0, b};
   assign diff_x = {1'b0, a} - {1'b0, b};
   assign sum    = sum_x[DATA_W-1:0];
   assign diff   = diff_x[DATA_W-1:0];

   always_comb begin
      carry = 1'b0;
      case (op)
         OP_ADD:  carry = sum_x[DATA_W];
         OP_SUB:  carry = diff_x[DATA_W];
         default: carry = 1'b0;
      endcase
   end
`else
   assign sum  = a + b;
   assign diff = a - b;
`endif

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = sum;
         OP_SUB:  result = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rf_seq_alu.sv
// Sequenced execute stage driving a single-port register file.
// Reads rs1 then rs2 over the shared address port, computes, and writes rd.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operation handshake (in_ready combinational from state)
//   in_op/rd/rs1/rs2  : operation and register numbers; in_imm for LI
//   rf_addr/ren/wen/wdata, rf_rdata : register file port (rdata combinational)
//   done, result      : writeback pulse and last written result
//   flag_z, flag_c    : zero / carry flags (only with RF_SEQ_ALU_FLAGS_EN)
// Optional feature macro: RF_SEQ_ALU_FLAGS_EN
module rf_seq_alu #(
   parameter int unsigned DATA_W = rf_seq_alu_pkg::DATA_W,
   parameter int unsigned ADDR_W = rf_seq_alu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_ren,
   output logic              rf_wen,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              done,
   output logic [DATA_W-1:0] result
`ifdef RF_SEQ_ALU_FLAGS_EN
   ,
   output logic              flag_z,
   output logic              flag_c
`endif
);
   import rf_seq_alu_pkg::*;

   state_e            state;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs2_q;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_res;
`ifdef RF_SEQ_ALU_FLAGS_EN
   logic              alu_c;
`endif

   assign in_ready = (state == ST_IDLE) && !rst;

   rf_seq_alu_core #(.DATA_W(DATA_W)) u_core (
      .op     (op_q),
      .a      (op_a),
      .b      (op_b),
      .result (alu_res)
`ifdef RF_SEQ_ALU_FLAGS_EN
      ,
      .carry  (alu_c)
`endif
   );

   // Sequencer; RF port outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rs2_q    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         rf_addr  <= '0;
         rf_ren   <= 1'b0;
         rf_wen   <= 1'b0;
         rf_wdata <= '0;
         done     <= 1'b0;
         result   <= '0;
`ifdef RF_SEQ_ALU_FLAGS_EN
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
`endif
      end else begin
         // Strobes and the port are idle unless the next state drives them.
         rf_addr  <= '0;
         rf_ren   <= 1'b0;
         rf_wen   <= 1'b0;
         rf_wdata <= '0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= in_op;
                  rd_q  <= in_rd;
                  rs2_q <= in_rs2;
                  if (in_op == 3'(OP_LI)) begin
                     state    <= ST_WB;
                     rf_addr  <= in_rd;
                     rf_wen   <= (in_rd != '0);
                     rf_wdata <= in_imm;
                     done     <= 1'b1;
                     result   <= in_imm;
`ifdef RF_SEQ_ALU_FLAGS_EN
                     flag_z   <= (in_imm == '0);
                     flag_c   <= 1'b0;
`endif
                  end else if (!op_reserved(in_op)) begin
                     state   <= ST_RD_A;
                     rf_addr <= in_rs1;
                     rf_ren  <= 1'b1;
                  end
               end
            end
            ST_RD_A: begin
               op_a    <= rf_rdata;
               rf_addr <= rs2_q;
               rf_ren  <= 1'b1;
               state   <= ST_RD_B;
            end
            ST_RD_B: begin
               op_b  <= rf_rdata;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               result   <= alu_res;
               rf_addr  <= rd_q;
               rf_wen   <= (rd_q != '0);
               rf_wdata <= alu_res;
               done     <= 1'b1;
`ifdef RF_SEQ_ALU_FLAGS_EN
               flag_z   <= (alu_res == '0);
               flag_c   <= alu_c;
`endif
               state    <= ST_WB;
            end
            ST_WB:   state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_seq_alu.sv
// Self-checking bench for rf_seq_alu: register file model, directed cases,
// then randomized operations against a reference register array.
// Optional feature macro: RF_SEQ_ALU_FLAGS_EN
module tb_rf_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [3:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic [3:0]  rf_addr;
   logic        rf_ren, rf_wen;
   logic [31:0] rf_wdata, rf_rdata;
   logic        done;
   logic [31:0] result;
`ifdef RF_SEQ_ALU_FLAGS_EN
   logic        flag_z, flag_c;
   bit          exp_c;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rf_mem [0:15];
   logic [31:0] ref_rf [0:15];
   logic        load_rf;

   always #5 clk = ~clk;

   rf_seq_alu dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_rd    (in_rd),
      .in_rs1   (in_rs1),
      .in_rs2   (in_rs2),
      .in_imm   (in_imm),
      .rf_addr  (rf_addr),
      .rf_ren   (rf_ren),
      .rf_wen   (rf_wen),
      .rf_wdata (rf_wdata),
      .rf_rdata (rf_rdata),
      .done     (done),
      .result   (result)
`ifdef RF_SEQ_ALU_FLAGS_EN
      ,
      .flag_z   (flag_z),
      .flag_c   (flag_c)
`endif
   );

   // Register file: r0 reads as zero, combinational read, write on clock edge.
   assign rf_rdata = (rf_addr == 4'd0) ? 32'd0 : rf_mem[rf_addr];

   always @(posedge clk) begin
      if (load_rf) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= 32'd0;
         rf_mem[1] <= 32'd5;
         rf_mem[2] <= 32'd6;
      end else if (rf_wen && rf_addr != 4'd0) begin
         rf_mem[rf_addr] <= rf_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic wb_check(input logic [3:0] rd, input logic [31:0] res);
      chk("wb_addr",   32'(rf_addr), 32'(rd));
      chk("wb_wen",    32'(rf_wen), 32'(rd != 4'd0));
      chk("wb_ren",    32'(rf_ren), 32'd0);
      chk("wb_wdata",  rf_wdata, res);
      chk("wb_done",   32'(done), 32'd1);
      chk("wb_result", result, res);
      chk("wb_ready",  32'(in_ready), 32'd0);
`ifdef RF_SEQ_ALU_FLAGS_EN
      chk("wb_flag_z", 32'(flag_z), 32'(res == 32'd0));
      chk("wb_flag_c", 32'(flag_c), 32'(exp_c));
`endif
   endtask

   task automatic idle_check(input logic [31:0] res);
      chk("idle_ready",  32'(in_ready), 32'd1);
      chk("idle_done",   32'(done), 32'd0);
      chk("idle_strobe", {30'd0, rf_ren, rf_wen}, 32'd0);
      chk("idle_result", result, res);
   endtask

   // Called at a falling edge while the DUT is idle; returns at the falling
   // edge of the next idle cycle, leaving in_valid high when keep is set.
   task automatic do_op(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] imm, input bit keep);
      logic [31:0] a, b, res, prev_res;
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      prev_res = result;
      chk("accept_ready", 32'(in_ready), 32'd1);
      a = ref_rf[rs1];
      b = ref_rf[rs2];
      case (op)
         3'd0:    res = a + b;
         3'd1:    res = a - b;
         3'd2:    res = a & b;
         3'd3:    res = a | b;
         3'd4:    res = a ^ b;
         3'd5:    res = imm;
         default: res = 32'd0;
      endcase
`ifdef RF_SEQ_ALU_FLAGS_EN
      exp_c = (op == 3'd0) ? ((64'(a) + 64'(b)) > 64'hFFFF_FFFF) : (op == 3'd1) ? (a < b) : 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
      if (op > 3'd5) begin
         idle_check(prev_res);
         chk("rsv_addr", 32'(rf_addr), 32'd0);
         return;
      end
      if (op != 3'd5) begin
         chk("rda_addr",  32'(rf_addr), 32'(rs1));
         chk("rda_ren",   32'(rf_ren), 32'd1);
         chk("rda_wen",   32'(rf_wen), 32'd0);
         chk("rda_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
         chk("rdb_addr",  32'(rf_addr), 32'(rs2));
         chk("rdb_ren",   32'(rf_ren), 32'd1);
         chk("rdb_wen",   32'(rf_wen), 32'd0);
         @(negedge clk);
         chk("exec_port", {26'd0, rf_addr, rf_ren, rf_wen}, 32'd0);
         chk("exec_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      wb_check(rd, res);
      @(negedge clk);
      idle_check(res);
      if (rd != 4'd0) ref_rf[rd] = res;
   endtask

   logic [2:0]  r_op;
   logic [31:0] r_imm;

   initial begin
      for (int i = 0; i < 16; i++) ref_rf[i] = 32'd0;
      ref_rf[1] = 32'd5;
      ref_rf[2] = 32'd6;
      rst = 1'b1; load_rf = 1'b1; in_valid = 1'b0;
      in_op = 3'd0; in_rd = 4'd0; in_rs1 = 4'd0; in_rs2 = 4'd0; in_imm = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      load_rf = 1'b0;
      chk("rst_ready",  32'(in_ready), 32'd0);
      chk("rst_port",   {26'd0, rf_addr, rf_ren, rf_wen}, 32'd0);
      chk("rst_wdata",  rf_wdata, 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      do_op(3'd0, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);       // ADD r3 = 5 + 6
      do_op(3'd1, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);       // SUB r3 = 5 - 6
      do_op(3'd5, 4'd0, 4'd0, 4'd0, 32'h1234, 1'b0);    // LI r0: no write
      do_op(3'd3, 4'd3, 4'd0, 4'd0, 32'd0, 1'b0);       // r0 still reads 0
      do_op(3'd0, 4'd3, 4'd1, 4'd2, 32'd0, 1'b1);       // back-to-back ADD
      do_op(3'd4, 4'd2, 4'd1, 4'd1, 32'd0, 1'b0);       // then XOR r1^r1

      // Reset during RD_B aborts the op without writeback.
      in_op = 3'd0; in_rd = 4'd3; in_rs1 = 4'd1; in_rs2 = 4'd2; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready",  32'(in_ready), 32'd0);
      chk("abort_port",   {26'd0, rf_addr, rf_ren, rf_wen}, 32'd0);
      chk("abort_done",   32'(done), 32'd0);
      chk("abort_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      idle_check(32'd0);

      do_op(3'd7, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);       // reserved op dropped

      for (int n = 0; n < 60; n++) begin
         r_op  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
         r_imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
         do_op(r_op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), r_imm, 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) chk("rf_final", rf_mem[i], ref_rf[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
